// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: redirect encodings,
// FSM states and instruction field positions.
package fetch_pkg;

    // Matches the control decoder's selpctype encoding.
    localparam logic [1:0] PCTYPE_BR  = 2'b00;
    localparam logic [1:0] PCTYPE_JR  = 2'b01;
    localparam logic [1:0] PCTYPE_J   = 2'b10;
    localparam logic [1:0] PCTYPE_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam int OP_LSB    = 26;
    localparam int OP_W      = 6;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int REG_W     = 5;
    localparam int SHAMT_LSB = 6;
    localparam int FN_LSB    = 0;
    localparam int FN_W      = 6;
    localparam int IMM_W     = 16;
    localparam int TGT_W     = 26;

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational redirect target: branch adder, jump concatenation, jr pass-through.
// Target is produced unaligned; the fetch stage decides what to do with bits [1:0].
module fetch_target_calc
    import fetch_pkg::*;
(
    input  logic [1:0]  pctype,
    input  logic [31:0] pc4,
    input  logic [15:0] imm,
    input  logic [25:0] jidx,
    input  logic [31:0] reg_val,
    output logic [31:0] target,
    output logic        target_vld
);

    logic [31:0] br_off;

    assign br_off = {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        target     = '0;
        target_vld = 1'b0;
        case (pctype)
            PCTYPE_BR: begin
                target     = pc4 + br_off;
                target_vld = 1'b1;
            end
            PCTYPE_JR: begin
                target     = reg_val;
                target_vld = 1'b1;
            end
            PCTYPE_J: begin
                target     = {pc4[31:28], jidx, 2'b00};
                target_vld = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_fetch.sv
// Non-pipelined fetch stage: REQ -> WAIT -> HOLD, with redirects from execute.
// Build macro IFETCH_ALIGN_CHECK_EN parks fetch on misaligned targets instead of masking them.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [5:0]        out_op,
    output logic [5:0]        out_fn,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [15:0]       out_imm,
    output logic [25:0]       out_target,
    output logic [ADDR_W-1:0] out_pc4,
`ifdef IFETCH_ALIGN_CHECK_EN
    output logic              fetch_misalign,
`endif
    input  logic              redir_en,
    input  logic [1:0]        redir_pctype,
    input  logic [ADDR_W-1:0] redir_pc4,
    input  logic [15:0]       redir_imm,
    input  logic [25:0]       redir_target,
    input  logic [ADDR_W-1:0] redir_reg
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic [31:0]       instr_q, instr_d;
    logic              kill_q, kill_d;
    logic              valid_q, valid_d;
    logic [31:0]       tgt_raw, tgt_pc;
    logic              tgt_vld, redir_go, park;

    fetch_target_calc u_tgt (
        .pctype     (redir_pctype),
        .pc4        (redir_pc4),
        .imm        (redir_imm),
        .jidx       (redir_target),
        .reg_val    (redir_reg),
        .target     (tgt_raw),
        .target_vld (tgt_vld)
    );

    assign redir_go = redir_en && tgt_vld;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign tgt_pc         = tgt_raw;
    assign park           = misalign_q;
    assign fetch_misalign = misalign_q;
`else
    assign tgt_pc = tgt_raw & ~32'h3;
    assign park   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        pc4_d      = pc4_q;
        instr_d    = instr_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
`ifdef IFETCH_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_REQ: begin
                if (!park) begin
                    state_d    = ST_WAIT;
                    req_addr_d = pc_q;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        pc4_d   = pc_q + 32'd4;
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // Redirect overrides whatever the ack/ready path decided above.
        if (redir_go) begin
            pc_d    = tgt_pc;
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = 1'b0;
            if (state_q == ST_WAIT && !imem_ack) begin
                state_d = ST_WAIT;
                kill_d  = 1'b1;
            end else begin
                state_d = ST_REQ;
                kill_d  = 1'b0;
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            misalign_d = |tgt_raw[1:0];
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            pc4_q      <= '0;
            instr_q    <= '0;
            kill_q     <= 1'b0;
            valid_q    <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            pc4_q      <= pc4_d;
            instr_q    <= instr_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
`ifdef IFETCH_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Gated by reset so no request escapes while reset is held; the address of an
    // outstanding request stays frozen in WAIT even if pc is redirected underneath it.
    assign imem_req  = !reset && (state_q == ST_WAIT || (state_q == ST_REQ && !park));
    assign imem_addr = (state_q == ST_WAIT) ? req_addr_q : pc_q;

    assign out_valid  = valid_q;
    assign out_instr  = instr_q;
    assign out_pc4    = pc4_q;
    assign out_op     = instr_q[OP_LSB +: OP_W];
    assign out_fn     = instr_q[FN_LSB +: FN_W];
    assign out_rs     = instr_q[RS_LSB +: REG_W];
    assign out_rt     = instr_q[RT_LSB +: REG_W];
    assign out_rd     = instr_q[RD_LSB +: REG_W];
    assign out_shamt  = instr_q[SHAMT_LSB +: REG_W];
    assign out_imm    = instr_q[0 +: IMM_W];
    assign out_target = instr_q[0 +: TGT_W];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: target-calc vector table, directed corner sequences,
// then randomized traffic against a transaction-level fetch model.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc4;
    logic [5:0]  out_op, out_fn;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] out_imm;
    logic [25:0] out_target;
    logic        redir_en;
    logic [1:0]  redir_pctype;
    logic [31:0] redir_pc4, redir_reg;
    logic [15:0] redir_imm;
    logic [25:0] redir_target;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    logic [1:0]  c_pt;
    logic [31:0] c_pc4, c_rg, c_tgt;
    logic [15:0] c_imm;
    logic [25:0] c_jidx;
    logic        c_vld;

    int total = 0;
    int bad   = 0;
    int mem_cnt = 0;
    int mem_lat = 1;
    bit rnd_lat = 0;

    always #5 clock = ~clock;

    instr_fetch #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_op(out_op), .out_fn(out_fn), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_imm(out_imm), .out_target(out_target), .out_pc4(out_pc4),
`ifdef IFETCH_ALIGN_CHECK_EN
        .fetch_misalign(fetch_misalign),
`endif
        .redir_en(redir_en), .redir_pctype(redir_pctype), .redir_pc4(redir_pc4),
        .redir_imm(redir_imm), .redir_target(redir_target), .redir_reg(redir_reg)
    );

    fetch_target_calc u_calc (
        .pctype(c_pt), .pc4(c_pc4), .imm(c_imm), .jidx(c_jidx), .reg_val(c_rg),
        .target(c_tgt), .target_vld(c_vld)
    );

    typedef struct {
        logic [1:0]  pt;
        logic [31:0] pc4;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] rg;
        logic [31:0] exp_t;
        logic        exp_v;
    } calc_vec_t;

    calc_vec_t vecs[9];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0020;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] model_tgt(input logic [1:0] pt, input logic [31:0] pc4,
                                              input logic [15:0] imm, input logic [25:0] jidx,
                                              input logic [31:0] rg);
        int off;
        off = $signed(imm);
        case (pt)
            2'b00:   return pc4 + 32'(off * 4);
            2'b10:   return (pc4 & 32'hF000_0000) + 32'(jidx) * 4;
            default: return rg;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock; then the memory model decides its ack for the next edge.
    task automatic cyc();
        @(posedge clock);
        #2;
        if (imem_req) begin
            mem_cnt++;
            if (mem_cnt > mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_cnt    = 0;
                if (rnd_lat) mem_lat = $urandom_range(1, 3);
            end else begin
                imem_ack = 1'b0;
            end
        end else begin
            mem_cnt  = 0;
            imem_ack = 1'b0;
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!out_valid && n < 40) begin
            cyc();
            n++;
        end
        if (!out_valid) chk(nm, 32'(out_valid), 32'd1);
    endtask

    task automatic redirect(input logic [1:0] pt, input logic [31:0] pc4, input logic [15:0] imm,
                            input logic [25:0] jidx, input logic [31:0] rg);
        redir_en = 1'b1; redir_pctype = pt; redir_pc4 = pc4;
        redir_imm = imm; redir_target = jidx; redir_reg = rg;
        cyc();
        redir_en = 1'b0;
    endtask

    initial begin
        logic [31:0] w, held, first_addr, exp_pc, prev_instr;
        bit got, prev_held, go;
        int accepts;

        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; out_ready = 1'b1;
        redir_en = 1'b0; redir_pctype = '0; redir_pc4 = '0; redir_imm = '0;
        redir_target = '0; redir_reg = '0;

        // Target calculator in isolation.
        vecs[0] = '{2'b00, 32'h0000_0100, 16'hFFFE, 26'h0, 32'h0, 32'h0000_00F8, 1'b1};
        vecs[1] = '{2'b00, 32'h0000_0100, 16'h0010, 26'h0, 32'h0, 32'h0000_0140, 1'b1};
        vecs[2] = '{2'b00, 32'h0000_0000, 16'h8000, 26'h0, 32'h0, 32'hFFFE_0000, 1'b1};
        vecs[3] = '{2'b00, 32'hFFFF_FFF0, 16'h0008, 26'h0, 32'h0, 32'h0000_0010, 1'b1};
        vecs[4] = '{2'b10, 32'hA000_0010, 16'h0, 26'h10, 32'h0, 32'hA000_0040, 1'b1};
        vecs[5] = '{2'b10, 32'h7FFF_FFFC, 16'h0, 26'h3FF_FFFF, 32'h0, 32'h7FFF_FFFC, 1'b1};
        vecs[6] = '{2'b01, 32'h0000_1234, 16'h5, 26'h5, 32'h0000_0400, 32'h0000_0400, 1'b1};
        vecs[7] = '{2'b01, 32'h0, 16'h0, 26'h0, 32'h0000_0403, 32'h0000_0403, 1'b1};
        vecs[8] = '{2'b11, 32'h0000_0100, 16'h1, 26'h1, 32'h55, 32'h0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            c_pt = vecs[i].pt; c_pc4 = vecs[i].pc4; c_imm = vecs[i].imm;
            c_jidx = vecs[i].jidx; c_rg = vecs[i].rg;
            #1;
            chk($sformatf("calc_vld[%0d]", i), 32'(c_vld), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) chk($sformatf("calc_tgt[%0d]", i), c_tgt, vecs[i].exp_t);
        end

        // Reset state.
        repeat (3) cyc();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc4", out_pc4, 32'd0);
        reset = 1'b0;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'd0);

        wait_valid("first_valid_timeout");
        chk("first_op", 32'(out_op), 32'd0);
        chk("first_fn", 32'(out_fn), 32'h20);
        chk("first_pc4", out_pc4, 32'd4);
        cyc();
        chk("next_addr", imem_addr, 32'd4);
        chk("next_req", 32'(imem_req), 32'd1);

        // Stall in HOLD for 5 cycles.
        out_ready = 1'b0;
        wait_valid("stall_valid_timeout");
        held = out_instr;
        chk("stall_instr", out_instr, mem_word(32'd4));
        chk("stall_pc4", out_pc4, 32'd8);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_instr", out_instr, held);
            chk("stall_no_req", 32'(imem_req), 32'd0);
        end
        out_ready = 1'b1;
        cyc();
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_addr", imem_addr, 32'd8);

        // Branch and jump redirects from HOLD.
        out_ready = 1'b0;
        wait_valid("br_valid_timeout");
        redirect(PCTYPE_BR, 32'h100, 16'hFFFE, 26'h0, 32'h0);
        chk("br_drop_valid", 32'(out_valid), 32'd0);
        chk("br_addr", imem_addr, 32'h0000_00F8);
        wait_valid("br_fetch_timeout");
        chk("br_pc4", out_pc4, 32'h0000_00FC);
        chk("br_instr", out_instr, mem_word(32'hF8));
        redirect(PCTYPE_J, 32'hA000_0010, 16'h0, 26'h10, 32'h0);
        chk("j_addr", imem_addr, 32'hA000_0040);
        wait_valid("j_fetch_timeout");
        chk("j_pc4", out_pc4, 32'hA000_0044);

        // Reserved pctype does nothing.
        redirect(PCTYPE_RSV, 32'h100, 16'h1, 26'h1, 32'h800);
        chk("rsv_valid", 32'(out_valid), 32'd1);
        chk("rsv_pc4", out_pc4, 32'hA000_0044);

        // Redirect beats out_ready in HOLD, then redirect mid-WAIT kills the response.
        out_ready = 1'b1;
        redirect(PCTYPE_JR, 32'h0, 16'h0, 26'h0, 32'h8);
        chk("hold_redir_valid", 32'(out_valid), 32'd0);
        chk("hold_redir_addr", imem_addr, 32'd8);
        mem_lat = 3;
        cyc();
        redirect(PCTYPE_JR, 32'h0, 16'h0, 26'h0, 32'h400);
        chk("kill_req_held", 32'(imem_req), 32'd1);
        chk("kill_addr_stable", imem_addr, 32'd8);
        got = 0; first_addr = '0;
        for (int n = 0; n < 30 && !out_valid; n++) begin
            if (imem_req && imem_addr != 32'd8 && !got) begin
                first_addr = imem_addr;
                got = 1;
            end
            cyc();
        end
        chk("kill_next_addr", first_addr, 32'h400);
        chk("kill_valid", 32'(out_valid), 32'd1);
        chk("kill_pc4", out_pc4, 32'h404);
        chk("kill_instr", out_instr, mem_word(32'h400));
        mem_lat = 1;

        // Redirect in the same cycle as the ack.
        for (int n = 0; n < 20 && !imem_ack; n++) cyc();
        chk("same_ack_seen", 32'(imem_ack), 32'd1);
        redirect(PCTYPE_JR, 32'h0, 16'h0, 26'h0, 32'h600);
        chk("same_drop_valid", 32'(out_valid), 32'd0);
        wait_valid("same_fetch_timeout");
        chk("same_pc4", out_pc4, 32'h604);

        // PC wrap.
        out_ready = 1'b0;
        cyc();
        wait_valid("wrap_pre_timeout");
        redirect(PCTYPE_JR, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("wrap_fetch_timeout");
        chk("wrap_pc4", out_pc4, 32'h0);
        out_ready = 1'b1;
        cyc();
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Misaligned jr target.
        out_ready = 1'b0;
        wait_valid("align_pre_timeout");
`ifdef IFETCH_ALIGN_CHECK_EN
        redirect(PCTYPE_JR, 32'h0, 16'h0, 26'h0, 32'h402);
        chk("misalign_set", 32'(fetch_misalign), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("misalign_parked", 32'(imem_req), 32'd0);
            cyc();
        end
        redirect(PCTYPE_JR, 32'h0, 16'h0, 26'h0, 32'h500);
        chk("misalign_clear", 32'(fetch_misalign), 32'd0);
        chk("misalign_resume_req", 32'(imem_req), 32'd1);
        chk("misalign_resume_addr", imem_addr, 32'h500);
`else
        redirect(PCTYPE_JR, 32'h0, 16'h0, 26'h0, 32'h403);
        chk("align_mask_addr", imem_addr, 32'h400);
`endif
        out_ready = 1'b1;

        // Random traffic vs. a model that tracks only the next PC to be delivered.
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        rnd_lat = 1;
        exp_pc = 32'h0; accepts = 0; prev_held = 0; prev_instr = '0;
        for (int cy = 0; cy < 3000; cy++) begin
            if (prev_held) begin
                chk("rnd_hold_valid", 32'(out_valid), 32'd1);
                chk("rnd_hold_instr", out_instr, prev_instr);
            end
            out_ready    = ($urandom_range(0, 3) != 0);
            redir_en     = ($urandom_range(0, 9) == 0);
            redir_pctype = 2'($urandom_range(0, 3));
            redir_pc4    = $urandom & ~32'h3;
            redir_imm    = 16'($urandom);
            redir_target = 26'($urandom);
            redir_reg    = $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
            redir_reg    = redir_reg & ~32'h3;
`endif
            go = redir_en && (redir_pctype != 2'b11);
            if (go) begin
                exp_pc = model_tgt(redir_pctype, redir_pc4, redir_imm, redir_target, redir_reg) & ~32'h3;
            end else if (out_valid && out_ready) begin
                w = mem_word(exp_pc);
                chk("rnd_instr", out_instr, w);
                chk("rnd_pc4", out_pc4, exp_pc + 32'd4);
                chk("rnd_op", 32'(out_op), 32'(w[31:26]));
                chk("rnd_rs_rt_rd", {17'd0, out_rs, out_rt, out_rd}, 32'(w[25:11]));
                chk("rnd_shamt_fn", {21'd0, out_shamt, out_fn}, 32'(w[10:0]));
                chk("rnd_imm_tgt", {out_target[25:16], out_imm}, 32'(w[25:0]));
                exp_pc = exp_pc + 32'd4;
                accepts++;
            end
            prev_held  = out_valid && !out_ready && !go;
            prev_instr = out_instr;
            cyc();
        end
        redir_en = 1'b0;
        chk("rnd_progress", 32'(accepts >= 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage. Owns the PC and requests words from instruction memory over a req/ack handshake.
- Splits each word into the op/fn/register/immediate fields consumed by the control decoder and the register file, and presents them to decode with a valid/ready handshake.
- Accepts redirects from execute using the decoder's selpctype encoding. It computes the branch, jump and jump-register targets itself.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC/address width. Fixed at 32 for target arithmetic; any other value is illegal.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  read request, held until imem_ack
- imem_addr  out  32  word address (PC), stable while imem_req=1
- imem_ack  in  1  one-cycle pulse, imem_rdata valid
- imem_rdata  in  32  instruction word
- out_valid  out  1  decode fields valid
- out_ready  in  1  decode accepts (0 = stall)
- out_instr  out  32  raw word
- out_op  out  6  instr[31:26]
- out_fn  out  6  instr[5:0]
- out_rs/out_rt/out_rd  out  5 each  instr[25:21]/[20:16]/[15:11]
- out_shamt  out  5  instr[10:6]
- out_imm  out  16  instr[15:0]
- out_target  out  26  instr[25:0]
- out_pc4  out  32  fetch PC + 4
- redir_en  in  1  one-cycle redirect strobe from execute
- redir_pctype  in  2  00 = branch taken, 01 = jr, 10 = j, 11 = reserved (ignored)
- redir_pc4  in  32  PC+4 of the redirecting instruction
- redir_imm  in  16  branch offset
- redir_target  in  26  jump index
- redir_reg  in  32  jr register value

Behaviour:
- Reset: pc=RESET_PC, state=REQ, imem_req=0, out_valid=0, all out_* fields=0, kill=0. First request is issued on the cycle after reset deasserts.
- FSM states: REQ, WAIT, HOLD.
  - REQ: assert imem_req with imem_addr=pc; go to WAIT.
  - WAIT: keep imem_req asserted until imem_ack.
    - On ack with kill=0: latch the word into the output register, set out_valid=1, out_pc4=pc+4, pc<=pc+4, go to HOLD.
    - On ack with kill=1: drop the word, clear kill, go to REQ.
  - HOLD: out_valid=1 and fields stable while out_ready=0.
    - On out_ready=1: clear out_valid next cycle, go to REQ.
    - Throughput: 1 instruction per 3 cycles minimum (not pipelined).
- Target computation (modulo 2^32):
  - branch = redir_pc4 + (sign-extend(redir_imm) << 2)
  - j = {redir_pc4[31:28], redir_target, 2'b00}
  - jr = redir_reg
  - pctype=11: no action.
- Redirect by state:
  - REQ or HOLD: pc<=target, out_valid<=0, state<=REQ. The held word is discarded even if out_ready=1 in the same cycle.
  - WAIT, no ack that cycle: pc<=target, kill<=1. The response is discarded when it arrives.
  - WAIT, with ack that cycle: discard that ack's word, pc<=target, go to REQ.
  - Redirect always wins over ack and over out_ready.
- Back-to-back redirects: the last one wins.
- Reset mid-WAIT: abandon the request. Memory must tolerate req dropping before ack.
- imem_ack outside WAIT: ignored.
- PC wrap 32'hFFFF_FFFC+4 gives 0, with no flag.

Optional Feature:
- Macro: IFETCH_ALIGN_CHECK_EN.
- Enabled:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect target with [1:0]≠0 is not fetched: pc<=target, fetch_misalign<=1, FSM parks in REQ with imem_req=0.
  - The flag clears only on reset or on a later aligned redirect, which resumes fetching.
- Disabled:
  - No port.
  - Target bits [1:0] are forced to 0 before loading pc.

Decomposition:
- Package fetch_pkg holds:
  - PCTYPE_BR=2'b00, PCTYPE_JR=2'b01, PCTYPE_J=2'b10, matching the control decoder's selpctype.
  - FSM state enum.
  - Field bit-position constants.
- One sub-module, fetch_target_calc: combinational target mux and adders, so the bench can check it in isolation.

Test Plan:
- Reset then ack every request with 1-cycle latency, data 32'h0000_0020 at 0 → out_op=0, out_fn=6'h20, out_pc4=4, next imem_addr=4.
- out_ready=0 for 5 cycles in HOLD → fields unchanged, no new imem_req; release → next request at pc+4.
- Branch redirect with pc4=32'h100, imm=16'hFFFE, pctype=00 → next imem_addr=32'hF8; j with pc4=32'hA000_0010, target=26'h10 → 32'hA000_0040.
- Redirect (jr, reg=32'h400) two cycles before ack of addr 8 → that word never appears on out_valid; next request is to 32'h400.
- Redirect and ack in the same cycle → acked word dropped, out_valid stays 0, fetch from target.
- With IFETCH_ALIGN_CHECK_EN, jr to 32'h402 → fetch_misalign=1, imem_req=0; then jr to 32'h500 → flag clears, fetch resumes at 32'h500.
